// File: rtl/abs_multichannel_ctrl.sv
// Multi-channel ABS valve controller: one slip FSM per wheel, a shared recovery
// pump with hang-time, and a sticky per-channel antilock timeout flag.
module abs_multichannel_ctrl #(
  parameter int NUM_WHEELS = 4,
  parameter int SPEED_W    = 8,
  parameter int SLIP_ENTER = 20,
  parameter int SLIP_EXIT  = 10,
  parameter int MIN_SPEED  = 5,
  parameter int MIN_HOLD   = 3,
  parameter int MAX_HOLD   = 15,
  parameter int PUMP_HANG  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_WHEELS*SPEED_W-1:0] wheel_speed,
  input  logic [SPEED_W-1:0]            vehicle_speed,
  input  logic                          brake_signal,
  input  logic                          accelerometer,
  input  logic                          engine_status,
  output logic [NUM_WHEELS-1:0]         vrc1,
  output logic [NUM_WHEELS-1:0]         vrc2,
  output logic                          recovery_pump,
  output logic                          abs_active,
  output logic [NUM_WHEELS-1:0]         timeout_flag
);

  localparam int PROD_W = SPEED_W + 7;
  localparam int SLIP_W = 7;
  localparam int CNT_W  = $clog2(MAX_HOLD + 1);
  localparam int HANG_W = $clog2(PUMP_HANG + 1);

  localparam logic [SLIP_W-1:0]  SLIP_ENTER_V  = SLIP_W'(SLIP_ENTER);
  localparam logic [SLIP_W-1:0]  SLIP_EXIT_V   = SLIP_W'(SLIP_EXIT);
  localparam logic [SPEED_W-1:0] MIN_SPEED_V   = SPEED_W'(MIN_SPEED);
  localparam logic [CNT_W-1:0]   MIN_HOLD_V    = CNT_W'(MIN_HOLD);
  localparam logic [CNT_W-1:0]   MAX_HOLD_V    = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0]   MAX_HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [HANG_W-1:0]  PUMP_HANG_V   = HANG_W'(PUMP_HANG);

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    ANTILOCK = 2'd1,
    RELEASE  = 2'd2,
    REAPPLY  = 2'd3
  } state_t;

  logic [NUM_WHEELS-1:0] in_antilock;
  logic [NUM_WHEELS-1:0] not_normal;

  for (genvar g = 0; g < NUM_WHEELS; g++) begin : g_ch
    logic [SPEED_W-1:0] ws;
    logic               slipping;
    logic [PROD_W-1:0]  prod;
    logic [PROD_W-1:0]  divisor;
    logic [PROD_W-1:0]  quotient;
    logic [SLIP_W-1:0]  slip;
    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               timeout_hit;
    logic               timeout;

    assign ws       = wheel_speed[g*SPEED_W +: SPEED_W];
    assign slipping = (vehicle_speed != '0) && (ws < vehicle_speed);
    assign prod     = PROD_W'(vehicle_speed - ws) * PROD_W'(100);
    // Divisor is pinned to 1 when the vehicle is stationary so no divide-by-zero exists.
    assign divisor  = slipping ? PROD_W'(vehicle_speed) : PROD_W'(1);
    assign quotient = prod / divisor;
    assign slip     = slipping ? SLIP_W'(quotient) : '0;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
      state_next  = state;
      timeout_hit = 1'b0;
      if (!engine_status) begin
        state_next = NORMAL;
      end else begin
        case (state)
          NORMAL:
            if (brake_signal && (vehicle_speed > MIN_SPEED_V) && (slip > SLIP_ENTER_V))
              state_next = ANTILOCK;
          ANTILOCK:
            if (cnt >= MAX_HOLD_LAST) begin
              state_next  = RELEASE;
              timeout_hit = 1'b1;
            end else if ((cnt >= MIN_HOLD_V) && (slip < SLIP_EXIT_V)) begin
              state_next = RELEASE;
            end
          RELEASE:
            state_next = ((slip > SLIP_ENTER_V) || accelerometer) ? ANTILOCK : REAPPLY;
          REAPPLY:
            if ((slip < SLIP_EXIT_V) && !brake_signal) state_next = NORMAL;
            else if (slip > SLIP_ENTER_V)              state_next = ANTILOCK;
          default:
            state_next = NORMAL;
        endcase
      end

      cnt_next = '0;
      if ((state == ANTILOCK) && (state_next == ANTILOCK))
        cnt_next = (cnt == MAX_HOLD_V) ? cnt : cnt + CNT_W'(1);
    end

    // NOTE: the reset branch sits in the sensitivity list so reset acts without a clock edge.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state   <= NORMAL;
        cnt     <= '0;
        timeout <= 1'b0;
      end else begin
        state   <= state_next;
        cnt     <= cnt_next;
        timeout <= timeout | timeout_hit;
      end
    end

    assign vrc1[g]         = (state != ANTILOCK);
    assign vrc2[g]         = (state == ANTILOCK) || (state == RELEASE);
    assign in_antilock[g]  = (state == ANTILOCK);
    assign not_normal[g]   = (state != NORMAL);
    assign timeout_flag[g] = timeout;
  end

  // Hang counter is reloaded on every ANTILOCK cycle, so it starts counting only after the last exit.
  logic [HANG_W-1:0] hang;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              hang <= '0;
    else if (!engine_status) hang <= '0;
    else if (|in_antilock)  hang <= PUMP_HANG_V;
    else if (hang != '0)    hang <= hang - HANG_W'(1);
  end

  assign recovery_pump = (|in_antilock) || (hang != '0);
  assign abs_active    = |not_normal;

endmodule

// File: tb/tb_abs_multichannel_ctrl.sv
// Directed self-checking bench for abs_multichannel_ctrl (4 wheels, 8-bit speeds).
module tb_abs_multichannel_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] wheel_speed;
  logic [7:0]  vehicle_speed;
  logic        brake_signal;
  logic        accelerometer;
  logic        engine_status;
  logic [3:0]  vrc1;
  logic [3:0]  vrc2;
  logic        recovery_pump;
  logic        abs_active;
  logic [3:0]  timeout_flag;

  int passed = 0;
  int total  = 0;

  abs_multichannel_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .wheel_speed   (wheel_speed),
    .vehicle_speed (vehicle_speed),
    .brake_signal  (brake_signal),
    .accelerometer (accelerometer),
    .engine_status (engine_status),
    .vrc1          (vrc1),
    .vrc2          (vrc2),
    .recovery_pump (recovery_pump),
    .abs_active    (abs_active),
    .timeout_flag  (timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ws(input int ch, input logic [7:0] v);
    wheel_speed[ch*8 +: 8] = v;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_vrc1"}, 32'(vrc1), 32'hF);
    check({tag, "_vrc2"}, 32'(vrc2), 32'h0);
    check({tag, "_abs"},  32'(abs_active), 32'h0);
  endtask

  initial begin
    reset         = 1'b1;
    wheel_speed   = '0;
    vehicle_speed = '0;
    brake_signal  = 1'b0;
    accelerometer = 1'b0;
    engine_status = 1'b1;
    #2;
    check("rst_vrc1", 32'(vrc1), 32'hF);
    check("rst_vrc2", 32'(vrc2), 32'h0);
    check("rst_pump", 32'(recovery_pump), 32'h0);
    check("rst_abs",  32'(abs_active), 32'h0);
    check("rst_tof",  32'(timeout_flag), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Boundary cases: none of these may enter ANTILOCK.
    vehicle_speed = 8'd100;
    wheel_speed   = {4{8'd100}};
    set_ws(0, 8'd70);
    step();
    check_idle("no_brake");               // slip 30 but brake released
    brake_signal = 1'b1;
    set_ws(0, 8'd80);
    step();
    check_idle("slip_eq_enter");          // slip exactly 20
    vehicle_speed = 8'd150;
    wheel_speed   = {4{8'd150}};
    set_ws(0, 8'd119);
    step();
    check_idle("slip_trunc");             // 3100/150 truncates to 20
    vehicle_speed = 8'd100;
    wheel_speed   = {4{8'd100}};
    set_ws(0, 8'd200);
    step();
    check_idle("ws_above_vs");            // wheel faster than vehicle -> slip 0
    vehicle_speed = 8'd5;
    set_ws(0, 8'd0);
    step();
    check_idle("vs_eq_min");              // slip 100 but vs not above 5
    vehicle_speed = 8'd0;
    step();
    check_idle("vs_zero");

    // T1: ch0 enters ANTILOCK one clock after the condition is sampled.
    vehicle_speed = 8'd100;
    wheel_speed   = {4{8'd100}};
    set_ws(0, 8'd70);
    step();
    check("t1_vrc1", 32'(vrc1), 32'hE);
    check("t1_vrc2", 32'(vrc2), 32'h1);
    check("t1_pump", 32'(recovery_pump), 32'h1);
    check("t1_abs",  32'(abs_active), 32'h1);

    // T2: low slip, ANTILOCK held for cnt 0..3, then RELEASE, then REAPPLY.
    set_ws(0, 8'd95);
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("t2_hold%0d", i), 32'(vrc2), 32'h1);
    end
    step();
    check("t2_rel_vrc1", 32'(vrc1), 32'hF);
    check("t2_rel_vrc2", 32'(vrc2), 32'h1);
    check("t2_rel_pump", 32'(recovery_pump), 32'h1);   // hang = 4
    step();
    check("t2_reap_vrc2", 32'(vrc2), 32'h0);
    check("t2_reap_abs",  32'(abs_active), 32'h1);
    check("t2_reap_pump", 32'(recovery_pump), 32'h1);  // hang = 3
    step();
    check("t2_hold_reap", 32'(abs_active), 32'h1);     // brake still on, holds
    check("t4_pump_h2",   32'(recovery_pump), 32'h1);

    // T4: ch1 enters during the hang; pump hang restarts after ch1 leaves.
    set_ws(1, 8'd70);
    step();
    check("t4_ch1_vrc1", 32'(vrc1), 32'hD);
    check("t4_ch1_vrc2", 32'(vrc2), 32'h2);
    set_ws(1, 8'd100);
    for (int i = 1; i <= 3; i++) step();
    check("t4_ch1_hold", 32'(vrc2), 32'h2);
    step();
    check("t4_ch1_rel_vrc1", 32'(vrc1), 32'hF);
    check("t4_ch1_rel_vrc2", 32'(vrc2), 32'h2);
    check("t4_hang1", 32'(recovery_pump), 32'h1);
    brake_signal = 1'b0;
    step();
    check("t4_hang2", 32'(recovery_pump), 32'h1);
    check("t2_abs_ch1_reap", 32'(abs_active), 32'h1);  // ch0 NORMAL, ch1 REAPPLY
    step();
    check("t4_hang3", 32'(recovery_pump), 32'h1);
    check("t2_back_normal", 32'(abs_active), 32'h0);
    step();
    check("t4_hang4", 32'(recovery_pump), 32'h1);
    step();
    check("t4_hang_off", 32'(recovery_pump), 32'h0);

    // T3: slip exactly at exit threshold keeps ANTILOCK until the timeout forces RELEASE.
    brake_signal = 1'b1;
    set_ws(0, 8'd70);
    step();
    check("t3_enter", 32'(vrc2), 32'h1);
    set_ws(0, 8'd90);
    for (int i = 1; i <= 14; i++) step();
    check("t3_hold14_vrc1", 32'(vrc1), 32'hE);         // slip == 10 never exits
    check("t3_hold14_tof",  32'(timeout_flag), 32'h0);
    set_ws(0, 8'd70);
    step();
    check("t3_forced_vrc1", 32'(vrc1), 32'hF);
    check("t3_forced_vrc2", 32'(vrc2), 32'h1);
    check("t3_tof_set",     32'(timeout_flag), 32'h1);
    step();
    check("t3_reenter", 32'(vrc1), 32'hE);
    check("t3_tof_sticky", 32'(timeout_flag), 32'h1);

    // T5: ch0 in ANTILOCK, ch2 driven into REAPPLY, then engine off.
    set_ws(2, 8'd70);
    step();
    check("t5_ch2_enter", 32'(vrc2), 32'h5);
    set_ws(2, 8'd95);
    for (int i = 1; i <= 5; i++) step();
    check("t5_pre_vrc1", 32'(vrc1), 32'hE);
    check("t5_pre_vrc2", 32'(vrc2), 32'h1);
    engine_status = 1'b0;
    step();
    check("t5_off_vrc1", 32'(vrc1), 32'hF);
    check("t5_off_vrc2", 32'(vrc2), 32'h0);
    check("t5_off_pump", 32'(recovery_pump), 32'h0);
    check("t5_off_abs",  32'(abs_active), 32'h0);
    check("t5_off_tof",  32'(timeout_flag), 32'h1);

    // Asynchronous reset in the middle of an ANTILOCK cycle.
    engine_status = 1'b1;
    step();
    check("t5_rearm", 32'(vrc2), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_vrc1", 32'(vrc1), 32'hF);
    check("arst_vrc2", 32'(vrc2), 32'h0);
    check("arst_pump", 32'(recovery_pump), 32'h0);
    check("arst_abs",  32'(abs_active), 32'h0);
    check("arst_tof",  32'(timeout_flag), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("post_rst_enter", 32'(vrc2), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
